// File: rtl/drlp_pkg.sv
// Shared definitions for the MAC cluster datapath: activation/partial-sum
// widths, saturation limits, packer state encoding and the rounding
// right-shift with saturation used by the requantizer and the bias/ReLU path.
package drlp_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PSUM_WIDTH = DATA_WIDTH * 2 + 6;
  localparam int QMAX       = 2 ** (DATA_WIDTH - 1) - 1;
  localparam int QMIN       = -(2 ** (DATA_WIDTH - 1));

  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_FILL = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic                  sat;
    logic [DATA_WIDTH-1:0] q;
  } rq_result_t;

  // Round-half-up right shift by 'shift', then clamp to the activation range.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic rq_result_t sat_round(input logic [PSUM_WIDTH-1:0] sum,
                                           input logic [4:0]            shift);
    logic signed [PSUM_WIDTH:0] rnd;
    logic signed [PSUM_WIDTH:0] r;
    logic signed [PSUM_WIDTH:0] q;
    logic signed [PSUM_WIDTH:0] qmax_w;
    logic signed [PSUM_WIDTH:0] qmin_w;
    rq_result_t                 res;
    qmax_w = $signed((PSUM_WIDTH + 1)'(QMAX));
    qmin_w = $signed((PSUM_WIDTH + 1)'(QMIN));
    rnd    = '0;
    if (shift != 5'd0) begin
      rnd = $signed((PSUM_WIDTH + 1)'(1) << (shift - 5'd1));
    end
    r = $signed({sum[PSUM_WIDTH-1], sum}) + rnd;
    q = r >>> shift;
    if (q > qmax_w) begin
      res.sat = 1'b1;
      res.q   = DATA_WIDTH'(QMAX);
    end else if (q < qmin_w) begin
      res.sat = 1'b1;
      res.q   = DATA_WIDTH'(QMIN);
    end else begin
      res.sat = 1'b0;
      res.q   = q[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on dout.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle, so a full FIFO can stream at one word per cycle.
module sync_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since empty gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/psum_requantizer.sv
// Requantizes signed partial sums to activations (rounding shift + clamp),
// packs PACK activations per word and buffers words in a show-ahead FIFO.
// Optional feature: PSUM_REQUANT_MAXPOOL2_EN inserts a 2:1 max-pool stage
// between the quantizer and the packer.
module psum_requantizer
  import drlp_pkg::rq_result_t;
  import drlp_pkg::sat_round;
  import drlp_pkg::pack_state_e;
  import drlp_pkg::PK_IDLE;
  import drlp_pkg::PK_FILL;
#(
  parameter int DATA_WIDTH = drlp_pkg::DATA_WIDTH,
  parameter int IN_WIDTH   = drlp_pkg::PSUM_WIDTH,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_sum,
  input  logic                       in_last,
  input  logic [4:0]                 in_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic                       out_stall,
  output logic                       out_sat,
  output logic                       out_overflow
);

  localparam int CNT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
`ifdef PSUM_REQUANT_MAXPOOL2_EN
  localparam int STALL_MARGIN = 3;
`else
  localparam int STALL_MARGIN = 2;
`endif

  // ---------------- Stage Q: round, shift, saturate ----------------
  rq_result_t            rq_w;
  logic                  qv_q;
  logic [DATA_WIDTH-1:0] qdata_q;
  logic                  qlast_q;
  logic                  sat_q;

  assign rq_w = sat_round(in_sum, in_shift);

  // Register the quantized value and accumulate the sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      qv_q    <= 1'b0;
      qdata_q <= '0;
      qlast_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      qv_q <= in_valid;
      if (in_valid) begin
        qdata_q <= rq_w.q;
        qlast_q <= in_last;
        if (rq_w.sat) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  // ---------------- Optional pool stage ----------------
  logic                  pk_valid;
  logic [DATA_WIDTH-1:0] pk_data;
  logic                  pk_last;

`ifdef PSUM_REQUANT_MAXPOOL2_EN
  logic                  pool_have_q;
  logic [DATA_WIDTH-1:0] pool_val_q;
  logic                  pv_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic                  plast_q;

  // Pair consecutive values and forward the larger; a lone value ending a
  // row is forwarded as-is so the row still terminates.
  always_ff @(posedge clk) begin
    if (rst) begin
      pool_have_q <= 1'b0;
      pool_val_q  <= '0;
      pv_q        <= 1'b0;
      pdata_q     <= '0;
      plast_q     <= 1'b0;
    end else begin
      pv_q    <= 1'b0;
      plast_q <= 1'b0;
      if (qv_q) begin
        if (pool_have_q) begin
          pv_q        <= 1'b1;
          pdata_q     <= ($signed(qdata_q) > $signed(pool_val_q)) ? qdata_q : pool_val_q;
          plast_q     <= qlast_q;
          pool_have_q <= 1'b0;
        end else if (qlast_q) begin
          pv_q    <= 1'b1;
          pdata_q <= qdata_q;
          plast_q <= 1'b1;
        end else begin
          pool_have_q <= 1'b1;
          pool_val_q  <= qdata_q;
        end
      end
    end
  end

  assign pk_valid = pv_q;
  assign pk_data  = pdata_q;
  assign pk_last  = plast_q;
`else
  assign pk_valid = qv_q;
  assign pk_data  = qdata_q;
  assign pk_last  = qlast_q;
`endif

  // ---------------- Stage P: lane packer ----------------
  pack_state_e                           state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]       lanes_q, lanes_d;
  logic [PACK-1:0][DATA_WIDTH-1:0]       word_w;
  logic [CNT_W-1:0]                      lane_idx;
  logic                                  push_w;

  // Insert the incoming value into the current lane; emit on the last lane
  // or at end of row. Lanes are cleared after every push so unwritten lanes
  // of a flushed word read as zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lanes_d  = lanes_q;
    push_w   = 1'b0;
    lane_idx = (state_q == PK_IDLE) ? '0 : cnt_q;
    word_w   = lanes_q;
    if (pk_valid) begin
      word_w[lane_idx] = pk_data;
      if (pk_last || (lane_idx == CNT_W'(PACK - 1))) begin
        push_w  = 1'b1;
        cnt_d   = '0;
        lanes_d = '0;
        state_d = PK_IDLE;
      end else begin
        lanes_d = word_w;
        cnt_d   = lane_idx + 1'b1;
        state_d = PK_FILL;
      end
    end
  end

  // Packer state, lane counter and partial-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PK_IDLE;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  // ---------------- Output FIFO ----------------
  logic [PACK*DATA_WIDTH-1:0] fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FCW-1:0]             fifo_count;
  logic                       pop_w;
  logic                       overflow_q;
  logic                       stall_q;

  assign pop_w = !fifo_empty && out_ready;

  sync_fifo #(
    .WIDTH(PACK * DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_w),
    .pop  (pop_w),
    .din  (word_w),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Sticky drop flag and registered low-space warning for the controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      if (push_w && fifo_full && !pop_w) begin
        overflow_q <= 1'b1;
      end
      stall_q <= ((FCW'(FIFO_DEPTH) - fifo_count) <= FCW'(STALL_MARGIN));
    end
  end

  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_empty ? '0 : fifo_dout;
  assign out_stall    = stall_q;
  assign out_sat      = sat_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_psum_requantizer.sv
// Directed bench for psum_requantizer with hand-computed expected words.
// With PSUM_REQUANT_MAXPOOL2_EN defined the pooled-path vectors run instead
// of the plain-path vectors.
module tb_psum_requantizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [21:0] in_sum;
  logic        in_last;
  logic [4:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_stall;
  logic        out_sat;
  logic        out_overflow;

  int checks   = 0;
  int failures = 0;

  psum_requantizer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sum      (in_sum),
    .in_last     (in_last),
    .in_shift    (in_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_stall   (out_stall),
    .out_sat     (out_sat),
    .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic send(input int v, input logic last);
    in_valid = 1'b1;
    in_sum   = v[21:0];
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sum   = '0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_last   = 1'b0;
    in_shift  = 5'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_stall", {31'd0, out_stall}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);
    check("rst_ovf", {31'd0, out_overflow}, 32'd0);

`ifndef PSUM_REQUANT_MAXPOOL2_EN
    // Rounding, shift 4: 55->3, -55->-3, 0->0, 16->1
    in_shift = 5'd4;
    send(55, 1'b0);
    send(-55, 1'b0);
    send(0, 1'b0);
    send(16, 1'b0);
    check("rnd_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("rnd_valid", {31'd0, out_valid}, 32'd1);
    check("rnd_word", out_data, 32'h0100FD03);
    check("rnd_nosat", {31'd0, out_sat}, 32'd0);
    pop_one();
    check("rnd_popped", {31'd0, out_valid}, 32'd0);

    // Saturation, shift 2: 5000->127, -5000->-128, row ends on the second
    in_shift = 5'd2;
    send(5000, 1'b0);
    send(-5000, 1'b1);
    check("sat_flag", {31'd0, out_sat}, 32'd1);
    tick();
    check("sat_word", out_data, 32'h0000807F);
    pop_one();

    // Partial flush, shift 0
    in_shift = 5'd0;
    send(5, 1'b0);
    send(6, 1'b1);
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd1);
    check("flush_word", out_data, 32'h00000605);
    pop_one();
    send(7, 1'b1);
    tick();
    check("lane0_word", out_data, 32'h00000007);
    pop_one();
    check("sat_sticky", {31'd0, out_sat}, 32'd1);
    check("flush_empty", {31'd0, out_valid}, 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_cleared", {31'd0, out_sat}, 32'd0);

    // Backpressure: 16 values with consumer stalled, then 4 more
    for (int i = 1; i <= 16; i++) send(i, 1'b0);
    tick();
    tick();
    check("bp_stall", {31'd0, out_stall}, 32'd1);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head", out_data, 32'h04030201);
    check("bp_noovf", {31'd0, out_overflow}, 32'd0);
    for (int i = 17; i <= 20; i++) send(i, 1'b0);
    tick();
    check("bp_ovf", {31'd0, out_overflow}, 32'd1);
    check("bp_head_kept", out_data, 32'h04030201);
    out_ready = 1'b1;
    check("drain_w0", out_data, 32'h04030201);
    tick();
    check("drain_w1", out_data, 32'h08070605);
    tick();
    check("drain_w2", out_data, 32'h0C0B0A09);
    tick();
    check("drain_w3", out_data, 32'h100F0E0D);
    tick();
    out_ready = 1'b0;
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    tick();
    check("drain_stall", {31'd0, out_stall}, 32'd0);
    check("ovf_sticky", {31'd0, out_overflow}, 32'd1);

    // Reset in the middle of a row
    send(10, 1'b0);
    send(20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    tick();
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_word", out_data, 32'h04030201);
    pop_one();
    check("mid_single", {31'd0, out_valid}, 32'd0);
    check("mid_sat", {31'd0, out_sat}, 32'd0);
    check("mid_ovf", {31'd0, out_overflow}, 32'd0);
    check("mid_stall", {31'd0, out_stall}, 32'd0);
`else
    // Max-pool pairs, shift 0
    in_shift = 5'd0;
    send(3, 1'b0);
    send(9, 1'b0);
    send(-2, 1'b0);
    send(-7, 1'b0);
    send(1, 1'b0);
    send(0, 1'b0);
    send(4, 1'b0);
    send(8, 1'b0);
    tick();
    check("pool_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("pool_valid", {31'd0, out_valid}, 32'd1);
    check("pool_word", out_data, 32'h0801FE09);
    pop_one();
    check("pool_popped", {31'd0, out_valid}, 32'd0);

    // Odd-length row: trailing value forwarded alone
    send(7, 1'b0);
    send(2, 1'b0);
    send(5, 1'b1);
    tick();
    tick();
    check("pool_odd_valid", {31'd0, out_valid}, 32'd1);
    check("pool_odd_word", out_data, 32'h00000507);
    pop_one();
    check("pool_odd_empty", {31'd0, out_valid}, 32'd0);
    check("pool_sat", {31'd0, out_sat}, 32'd0);
    check("pool_ovf", {31'd0, out_overflow}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_requantizer.md
# psum_requantizer

Downstream stage of the MAC cluster: takes each completed signed partial-sum result (`out_total_sum`, qualified by the controller's done strobe) and requantizes it to DATA_WIDTH-bit activations by rounding right-shift and saturation. Four activations are packed per output word and buffered in a small FIFO toward the activation write-back path, with valid/ready on the output. A stall flag tells the layer controller to pause issuing `in_done` results when buffer space runs low.

## Interface
- `DATA_WIDTH`, default 8: output activation width.
- `IN_WIDTH`, default 22: partial-sum width, equal to DATA_WIDTH*2+6.
- `PACK`, default 4: activations per output word.
- `FIFO_DEPTH`, default 4: output words buffered.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_sum` holds a final result this cycle.
- `in_sum`  in  IN_WIDTH: signed final sum, two's complement.
- `in_last`  in  1: with `in_valid`, marks the last value of a row. Flushes a partial word.
- `in_shift`  in  5: right-shift amount, 0..IN_WIDTH-1. Must be held stable per layer.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: consumer accepts the head this cycle.
- `out_data`  out  PACK*DATA_WIDTH: packed word. Lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_stall`  out  1: free FIFO entries ≤ 2. The controller must not raise `in_valid` while it is set.
- `out_sat`  out  1: sticky. Set when any value saturates.
- `out_overflow`  out  1: sticky. Set when a word is dropped because the FIFO was full.

## Operation
- **Stage Q (registered).**
  - r = in_sum + (in_shift>0 ? 1<<(in_shift-1) : 0), computed at IN_WIDTH+1 bits.
  - q = r >>> in_shift (arithmetic shift).
  - Clamp q to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp sets `out_sat`.
  - `in_last` travels with the value.
- **Stage P (packer).**
  - Lane counter 0..PACK-1 writes each q into lane[cnt].
  - A word is pushed when cnt==PACK-1 or when `last` is set. Unwritten lanes are zero.
  - The counter returns to 0 after every push.
- **FIFO push rule.**
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and `out_overflow` is set.
- **FIFO pop.** Happens when `out_valid && out_ready`. The FIFO is show-ahead: the head is on `out_data`.
- **Packer states.** IDLE (cnt=0) → FILL (0<cnt<PACK) → IDLE, on push.
- **Reset values.** All outputs 0. Counter, FIFO pointers and occupancy, and sticky flags clear. In-flight stage Q data is discarded.
- **Reset mid-row.** The partial word is discarded; nothing is emitted.

## Timing
- Latency from `in_valid` at cycle t:
  - q is registered at t+1.
  - The word completes and is pushed at the t+2 edge.
  - `out_valid` rises in t+2 if the FIFO was empty.
- Throughput: one input per cycle, one output word per cycle.
- `out_stall` is registered from occupancy. The 2-entry margin covers the two in-flight stages plus the stall-flag latency.
- Sticky flags assert the cycle after the causing event.
- Simultaneous push and pop when full: both occur and occupancy is unchanged.
- Simultaneous push and pop when empty: `out_valid` rises in the following cycle.

## Configuration
- `PSUM_REQUANT_MAXPOOL2_EN` defined:
  - A pool register between stage Q and stage P pairs consecutive quantized values. Only max(a,b) goes to the packer, on the second of each pair.
  - If `last` arrives with a pair half-filled, the pending value is forwarded alone, with `last`.
  - Adds one cycle of latency; `out_valid` appears at t+3.
  - Pool pairing resets on `rst` and after every `last`.
  - `out_stall` margin becomes 3 free entries.
- Not defined: no pool register; every quantized value is packed.

## Structure
- Shared package `drlp_pkg`:
  - `DATA_WIDTH`, `PSUM_WIDTH` (= DATA_WIDTH*2+6).
  - `QMAX`/`QMIN` constants.
  - The saturate-and-round function, reused by the bias/ReLU path.
- Sub-module `sync_fifo`: parameterised width and depth, show-ahead, with full/empty/count outputs. Instantiated once.

## Test plan
- Rounding, in_shift=4:
  - in_sum=55 → q=3 (63>>>4).
  - in_sum=-55 → q=-3.
  - Pack 55, -55, 0, 16 → out_data=0x01_00_FD_03 at t+2 after the 4th input.
- Saturation, in_shift=2:
  - in_sum=5000 → 127.
  - in_sum=-5000 → -128.
  - `out_sat`=1 and stays 1 until `rst`.
- Partial flush: in_shift=0, values 5,6 with `in_last` on 6 → single word 0x00000605. The next row starts at lane 0.
- Backpressure:
  - out_ready=0, feed 16 values → 4 words held and `out_stall`=1.
  - A 17th–20th value feed (protocol violation) → `out_overflow`=1, and the FIFO contents are unchanged.
  - Then out_ready=1 → 4 words drain in order over 4 cycles.
- Reset mid-row: feed 2 values, assert `rst` for 1 cycle, then feed 1,2,3,4 → exactly one word 0x04030201. All flags are 0.
- With `PSUM_REQUANT_MAXPOOL2_EN` and in_shift=0:
  - Inputs 3,9,-2,-7,1,0,4,8 → word 0x0801FE09.
  - An odd row 7,2,5 with `last` on 5 → 0x00000507.
